running_mean_ctrl: RTL

Sequencer that runs the OCR training running-mean update across one stored feature vector, using the shared Into_1_min_1_by_n multiplier. For each feature word i it computes mean[i] <= mean[i]*(1-1/n) + x[i]*(1/n). It reads the sample RAM and the mean RAM, drives the multiplier, and writes the result back to the mean RAM. It sits between the training FSM (start/done) and the template memories.

---
 rtl/running_mean_pkg.sv | 31 +++
 rtl/running_mean_ctrl_if.sv | 32 +++
 rtl/rm_scale.sv | 27 ++
 rtl/running_mean_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/running_mean_pkg.sv
// Shared types and arithmetic for the running-mean sequencer.
// RUNNING_MEAN_ROUND_EN selects round-half-up in scale_q instead of truncation.
package running_mean_pkg;

  localparam int unsigned FRAC_W = 16;
  localparam int unsigned K_W    = FRAC_W + 1;
  localparam int unsigned MUL_W  = 32;
  localparam int unsigned PROD_W = MUL_W + K_W;

  localparam logic [K_W-1:0] ONE_Q = 17'd65536;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CALC,
    WR,
    FIN
  } state_e;

  // x * k in Q1.16, scaled back to an integer word
  function automatic logic [MUL_W-1:0] scale_q(input logic [MUL_W-1:0] x,
                                               input logic [K_W-1:0]   k);
    logic [PROD_W-1:0] p;
    p = PROD_W'(x) * PROD_W'(k);
`ifdef RUNNING_MEAN_ROUND_EN
    p = p + PROD_W'(ONE_Q >> 1);
`endif
    return MUL_W'(p >> FRAC_W);
  endfunction

endpackage

// File: rtl/running_mean_ctrl_if.sv
// Bundle of start/done, RAM and multiplier signals around the running-mean sequencer.
interface running_mean_ctrl_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
);
  import running_mean_pkg::*;

  logic              start;
  logic [K_W-1:0]    one_by_n;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] smp_addr;
  logic [DATA_W-1:0] smp_data;
  logic [ADDR_W-1:0] mean_addr;
  logic [DATA_W-1:0] mean_rdata;
  logic              mean_we;
  logic [DATA_W-1:0] mean_wdata;
  logic [MUL_W-1:0]  mul_d;
  logic [K_W-1:0]    mul_one_by_n;
  logic [MUL_W-1:0]  mul_prod;

  modport master (
    input  start, one_by_n, smp_data, mean_rdata, mul_prod,
    output busy, done, smp_addr, mean_addr, mean_we, mean_wdata, mul_d, mul_one_by_n
  );

  modport slave (
    output start, one_by_n, smp_data, mean_rdata, mul_prod,
    input  busy, done, smp_addr, mean_addr, mean_we, mean_wdata, mul_d, mul_one_by_n
  );

endinterface

// File: rtl/rm_scale.sv
// Registered-input scaler: holds one sample word and forms x*one_by_n >> FRAC_W.
module rm_scale
  import running_mean_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [MUL_W-1:0] x_in,
  input  logic [K_W-1:0]   k,
  output logic [MUL_W-1:0] xs_c
);

  logic [MUL_W-1:0] x_q, x_d;

  always_comb begin
    x_d = x_q;
    if (load) x_d = x_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) x_q <= '0;
    else     x_q <= x_d;
  end

  assign xs_c = scale_q(x_q, k);

endmodule

// File: rtl/running_mean_ctrl.sv
// Sequencer applying mean[i] = mean[i]*(1-1/n) + x[i]/n over one feature vector.
// Build option RUNNING_MEAN_ROUND_EN rounds the x/n term (see running_mean_pkg).
module running_mean_ctrl
  import running_mean_pkg::*;
#(
  parameter int unsigned NUM_FEAT = 64,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  running_mean_ctrl_if.master  bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_FEAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] smp_addr_q, smp_addr_d;
  logic [ADDR_W-1:0] mean_addr_q, mean_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mean_we_q, mean_we_d;
  logic [MUL_W-1:0]  mul_d_q, mul_d_d;
  logic [K_W-1:0]    k_q, k_d;

  logic              x_load_c;
  logic [MUL_W-1:0]  xs_c;
  logic [MUL_W:0]    sum_c;
  logic [DATA_W-1:0] wdata_c;

  rm_scale u_scale (
    .clk  (clk),
    .rst  (rst),
    .load (x_load_c),
    .x_in (MUL_W'(bus.smp_data)),
    .k    (k_q),
    .xs_c (xs_c)
  );

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    smp_addr_d  = smp_addr_q;
    mean_addr_d = mean_addr_q;
    mul_d_d     = mul_d_q;
    k_d         = k_q;
    done_d      = 1'b0;
    mean_we_d   = 1'b0;
    x_load_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          k_d         = (bus.one_by_n > ONE_Q) ? ONE_Q : bus.one_by_n;
          idx_d       = '0;
          smp_addr_d  = '0;
          mean_addr_d = '0;
          state_d     = RD;
        end
      end
      RD: begin
        state_d = CALC;
      end
      CALC: begin
        mul_d_d   = MUL_W'(bus.mean_rdata);
        x_load_c  = 1'b1;
        mean_we_d = 1'b1;
        state_d   = WR;
      end
      WR: begin
        if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          idx_d       = idx_q + 1'b1;
          smp_addr_d  = idx_q + 1'b1;
          mean_addr_d = idx_q + 1'b1;
          state_d     = RD;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      smp_addr_q  <= '0;
      mean_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mean_we_q   <= 1'b0;
      mul_d_q     <= '0;
      k_q         <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      smp_addr_q  <= smp_addr_d;
      mean_addr_q <= mean_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mean_we_q   <= mean_we_d;
      mul_d_q     <= mul_d_d;
      k_q         <= k_d;
    end
  end

  // Write data depends on the same-cycle multiplier result, so it is combinational
  // and gated to zero outside the write cycle.
  always_comb begin
    sum_c   = {1'b0, bus.mul_prod} + {1'b0, xs_c};
    wdata_c = '0;
    if (mean_we_q) begin
      if (sum_c[MUL_W]) wdata_c = DATA_W'({MUL_W{1'b1}});
      else              wdata_c = DATA_W'(sum_c[MUL_W-1:0]);
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.smp_addr     = smp_addr_q;
  assign bus.mean_addr    = mean_addr_q;
  assign bus.mean_we      = mean_we_q;
  assign bus.mean_wdata   = wdata_c;
  assign bus.mul_d        = mul_d_q;
  assign bus.mul_one_by_n = k_q;

endmodule
